// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_t;

  localparam int unsigned DM_WAIT_STATES_DEF = 2;
  localparam int unsigned DM_WORD_BITS       = 16;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic                    Rm;
  logic                    Wm;
  logic [DM_WORD_BITS-1:0] address;
  logic [DM_WORD_BITS-1:0] RegVal;
  logic [DM_WORD_BITS-1:0] Data_out;
  logic                    rd_valid;
  logic                    stall;
  logic                    oor;

  modport master (
    output Rm, Wm, address, RegVal,
    input  Data_out, rd_valid, stall, oor
  );

  modport slave (
    input  Rm, Wm, address, RegVal,
    output Data_out, rd_valid, stall, oor
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// Word RAM with synchronous write and a registered read port that can return zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [ADDR_BITS-1:0]    i_waddr,
  input  logic [DM_WORD_BITS-1:0] i_wdata,
  input  logic                    i_re,
  input  logic                    i_rclr,
  input  logic [ADDR_BITS-1:0]    i_raddr,
  output logic [DM_WORD_BITS-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DM_WORD_BITS-1:0] r_mem [DEPTH];
  logic [DM_WORD_BITS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value between reads; i_rclr forces a zero load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory answering after WAIT_STATES wait cycles, with a one-entry
// last-read register that lets a repeated load complete without stalling.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = DM_WAIT_STATES_DEF,
  parameter bit          HIT_EN      = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  dm_state_t               r_state;
  dm_state_t               w_next;
  logic [3:0]              r_wcnt;
  logic                    r_is_rd;
  logic                    r_oor;
  logic [DM_WORD_BITS-1:0] r_addr;
  logic [DM_WORD_BITS-1:0] r_data;
  logic [DM_WORD_BITS-1:0] r_last_addr;
  logic                    r_last_valid;

  logic                    w_req;
  logic                    w_rd_in;
  logic                    w_in_oor;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_enter_done;
  logic                    w_stall;
  logic                    w_rd_valid;
  logic                    w_oor;
  logic                    w_we;
  logic                    w_re;
  logic                    w_rclr;
  logic [ADDR_BITS-1:0]    w_raddr;
  logic [DM_WORD_BITS-1:0] w_rdata;

  assign w_req    = bus.Rm | bus.Wm;
  assign w_rd_in  = bus.Rm & ~bus.Wm;
  assign w_in_oor = (bus.address >> ADDR_BITS) != 16'h0000;
  assign w_hit    = HIT_EN & w_rd_in & r_last_valid & (bus.address == r_last_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DM_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DM_IDLE: if (w_req && !w_hit) w_next = (WAIT_STATES == 0) ? DM_DONE : DM_WAIT;
      DM_WAIT: if (r_wcnt == 4'd1) w_next = DM_DONE;
      DM_DONE: w_next = DM_IDLE;
      default: w_next = DM_IDLE;
    endcase
  end

  // Read data must be requested on the edge entering DONE; from IDLE (zero wait
  // states) the live inputs are used because nothing has been captured yet.
  always_comb begin
    w_accept     = 1'b0;
    w_stall      = 1'b0;
    w_rd_valid   = 1'b0;
    w_oor        = 1'b0;
    w_we         = 1'b0;
    w_enter_done = (w_next == DM_DONE) && (r_state != DM_DONE);
    w_re         = 1'b0;
    w_rclr       = r_oor;
    w_raddr      = r_addr[ADDR_BITS-1:0];
    case (r_state)
      DM_IDLE: begin
        w_accept   = w_req & ~w_hit;
        w_stall    = w_req & ~w_hit;
        w_rd_valid = w_hit;
        w_re       = w_enter_done & w_rd_in;
        w_rclr     = w_in_oor;
        w_raddr    = bus.address[ADDR_BITS-1:0];
      end
      DM_WAIT: begin
        w_stall = 1'b1;
        w_re    = w_enter_done & r_is_rd;
      end
      DM_DONE: begin
        w_rd_valid = r_is_rd;
        w_oor      = r_oor;
        w_we       = ~r_is_rd & ~r_oor;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt       <= '0;
      r_is_rd      <= 1'b0;
      r_oor        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt  <= WS_CNT;
        r_is_rd <= w_rd_in;
        r_oor   <= w_in_oor;
        r_addr  <= bus.address;
        r_data  <= bus.RegVal;
      end else if (r_state == DM_WAIT) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (r_state == DM_DONE) begin
        if (r_is_rd) begin
          r_last_addr  <= r_addr;
          r_last_valid <= ~r_oor;
        end else if (r_addr == r_last_addr) begin
          r_last_valid <= 1'b0;
        end
      end
    end
  end

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_we    (w_we),
    .i_waddr (r_addr[ADDR_BITS-1:0]),
    .i_wdata (r_data),
    .i_re    (w_re),
    .i_rclr  (w_rclr),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.Data_out = w_rdata;
  assign bus.rd_valid = w_rd_valid;
  assign bus.stall    = w_stall;
  assign bus.oor      = w_oor;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned WS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(WS), .HIT_EN(1'b1)) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  data_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .HIT_EN(1'b1)) u_dut0 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus0)
  );

  logic [15:0] m_mem [256];
  logic [15:0] m_last_addr;
  bit          m_last_valid;
  logic [15:0] m_dout;
  logic [15:0] m_recent;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One MEM-stage access on the main DUT; expectations come from the model.
  task automatic do_access(input bit rm, input bit wm, input logic [15:0] a, input logic [15:0] d);
    bit   is_rd;
    bit   a_oor;
    bit   hit;
    bit   done;
    int   st;
    int   exp_st;
    is_rd  = rm & ~wm;
    a_oor  = (a[15:8] != 8'h00);
    hit    = is_rd & m_last_valid & (a == m_last_addr);
    exp_st = hit ? 0 : int'(WS) + 1;
    st     = 0;
    done   = 1'b0;
    bus.Rm = rm; bus.Wm = wm; bus.address = a; bus.RegVal = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      st++;
    end
    check("complete", 16'(done), 16'd1);
    check("stall_cycles", 16'(st), 16'(exp_st));
    check("rd_valid", 16'(bus.rd_valid), 16'(is_rd));
    check("oor", 16'(bus.oor), 16'(a_oor));
    if (is_rd && !hit) begin
      m_dout       = a_oor ? 16'h0000 : m_mem[a[7:0]];
      m_last_addr  = a;
      m_last_valid = !a_oor;
    end
    check("Data_out", bus.Data_out, m_dout);
    if (wm) begin
      if (!a_oor) m_mem[a[7:0]] = d;
      if (a == m_last_addr) m_last_valid = 1'b0;
    end
    if (!a_oor) m_recent = a;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    bus.Rm = 1'b0; bus.Wm = 1'b0;
    @(negedge clk);
    check("idle_stall", 16'(bus.stall), 16'd0);
    check("idle_rd_valid", 16'(bus.rd_valid), 16'd0);
    @(posedge clk); #1;
  endtask

  // Directed access on the zero-wait-state DUT with explicit expectations.
  task automatic access0(input bit rm, input bit wm, input logic [15:0] a, input logic [15:0] d,
                         input int exp_st, input bit exp_rdv, input logic [15:0] exp_data);
    int st;
    bit done;
    st = 0;
    done = 1'b0;
    bus0.Rm = rm; bus0.Wm = wm; bus0.address = a; bus0.RegVal = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus0.stall) begin
        done = 1'b1;
        break;
      end
      st++;
    end
    check("ws0_complete", 16'(done), 16'd1);
    check("ws0_stall_cycles", 16'(st), 16'(exp_st));
    check("ws0_rd_valid", 16'(bus0.rd_valid), 16'(exp_rdv));
    check("ws0_Data_out", bus0.Data_out, exp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.Rm = 1'b0; bus.Wm = 1'b0; bus.address = '0; bus.RegVal = '0;
    bus0.Rm = 1'b0; bus0.Wm = 1'b0; bus0.address = '0; bus0.RegVal = '0;
    m_last_addr = '0; m_last_valid = 1'b0; m_dout = '0; m_recent = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_Data_out", bus.Data_out, 16'h0000);
    check("rst_stall", 16'(bus.stall), 16'd0);
    check("rst_rd_valid", 16'(bus.rd_valid), 16'd0);
    check("rst_oor", 16'(bus.oor), 16'd0);
    check("rst0_stall", 16'(bus0.stall), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) do_access(1'b0, 1'b1, 16'(i), 16'($urandom));

    // Reset in the middle of a write's wait states aborts it.
    bus.Wm = 1'b1; bus.address = 16'h0010; bus.RegVal = ~m_mem[16];
    @(negedge clk);
    check("abort_accept_stall", 16'(bus.stall), 16'd1);
    @(negedge clk);
    check("abort_wait_stall", 16'(bus.stall), 16'd1);
    rst_n = 1'b0;
    bus.Wm = 1'b0;
    #1;
    check("abort_Data_out", bus.Data_out, 16'h0000);
    check("abort_stall", 16'(bus.stall), 16'd0);
    check("abort_rd_valid", 16'(bus.rd_valid), 16'd0);
    m_last_valid = 1'b0;
    m_dout = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 16'h0010, 16'h0);

    do_access(1'b0, 1'b1, 16'h0005, 16'hBEEF);
    do_access(1'b1, 1'b0, 16'h0005, 16'h0);
    do_access(1'b1, 1'b0, 16'h0005, 16'h0);
    check("repeat_hit_data", bus.Data_out, 16'hBEEF);
    do_access(1'b0, 1'b1, 16'h0005, 16'h1234);
    do_access(1'b1, 1'b0, 16'h0005, 16'h0);
    check("reread_data", bus.Data_out, 16'h1234);

    do_access(1'b0, 1'b1, 16'h0000, 16'h5A5A);
    do_access(1'b1, 1'b0, 16'h0100, 16'h0);
    do_access(1'b0, 1'b1, 16'h0100, 16'hFFFF);
    idle_cycle();
    do_access(1'b1, 1'b0, 16'h0000, 16'h0);
    check("oor_write_dropped", bus.Data_out, 16'h5A5A);

    do_access(1'b1, 1'b1, 16'h0003, 16'h00AA);
    do_access(1'b1, 1'b0, 16'h0003, 16'h0);

    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [15:0] a;
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0:       a = 16'h0100 | 16'($urandom_range(0, 16'hFEFF));
        1, 2:    a = m_recent;
        default: a = 16'($urandom_range(0, 31));
      endcase
      if (op < 2)      idle_cycle();
      else if (op < 6) do_access(1'b1, 1'b0, a, 16'h0);
      else if (op < 9) do_access(1'b0, 1'b1, a, 16'($urandom));
      else             do_access(1'b1, 1'b1, a, 16'($urandom));
    end

    bus.Rm = 1'b0; bus.Wm = 1'b0;
    access0(1'b1, 1'b1, 16'h0003, 16'h00AA, 1, 1'b0, 16'h0000);
    access0(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 1'b1, 16'h00AA);
    access0(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1'b1, 16'h00AA);
    access0(1'b1, 1'b0, 16'h0200, 16'h0000, 1, 1'b1, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
